// File: rtl/corr_cfg_pkg.sv
// corr_cfg_pkg: opcodes, restore codes, FSM states and load targets for corr_config_ctrl
package corr_cfg_pkg;

    localparam logic [3:0] OP_RESTORE     = 4'd0;
    localparam logic [3:0] OP_LOAD_INTEG  = 4'd1;
    localparam logic [3:0] OP_LOAD_SAMPLE = 4'd2;
    localparam logic [3:0] OP_LOAD_LINE   = 4'd3;
    localparam logic [3:0] OP_ENABLES     = 4'd12;
    localparam logic [3:0] OP_COMMIT      = 4'd13;

    localparam logic [3:0] RS_INTEG   = 4'd1;
    localparam logic [3:0] RS_SAMPLE  = 4'd2;
    localparam logic [3:0] RS_LINE    = 4'd3;
    localparam logic [3:0] RS_ENABLES = 4'd12;
    localparam logic [3:0] RS_ALL     = 4'd15;

    typedef enum logic {ST_IDLE, ST_PENDING} state_t;

    typedef enum logic [1:0] {TGT_NONE, TGT_INTEG, TGT_SAMPLE, TGT_LINE} tgt_t;

    function automatic tgt_t op_target(input logic [3:0] op);
        return op == OP_LOAD_INTEG  ? TGT_INTEG  :
               op == OP_LOAD_SAMPLE ? TGT_SAMPLE :
               op == OP_LOAD_LINE   ? TGT_LINE   : TGT_NONE;
    endfunction

endpackage

// File: rtl/corr_config_ctrl_shadow_reg.sv
// corr_shadow_reg: one shadow setting with nibble write at a nibble index and restore to its init value
module corr_shadow_reg #(
    parameter int                 WIDTH = 64,
    parameter logic [WIDTH-1:0]   INIT  = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr,
    input  logic                        restore,
    input  logic [$clog2(WIDTH)-3:0]    nidx,
    input  logic [3:0]                  nib,
    output logic [WIDTH-1:0]            q
);

    always_ff @(posedge clk) begin
        if (rst || restore)
            q <= INIT;
        else if (wr)
            q[{nidx, 2'b00} +: 4] <= nib;
    end

endmodule

// File: rtl/corr_config_ctrl.sv
// corr_config_ctrl: byte command decoder building shadow settings and committing them on integration boundaries
module corr_config_ctrl
    import corr_cfg_pkg::*;
#(
    parameter int                     REG_WIDTH        = 64,
    parameter logic [REG_WIDTH-1:0]   INIT_ACTIVE_LINE = '0,
    parameter logic [REG_WIDTH-1:0]   INIT_SAMPLE_TIME = REG_WIDTH'(100),
    parameter logic [REG_WIDTH-1:0]   INIT_INTEG_TIME  = REG_WIDTH'(1000),
    parameter logic [2:0]             INIT_ENABLES     = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  integ_boundary,
    output logic [REG_WIDTH-1:0]  active_line,
    output logic [REG_WIDTH-1:0]  sample_time,
    output logic [REG_WIDTH-1:0]  integration_time,
    output logic                  transmit_enable,
    output logic                  integ_clk_enable,
    output logic                  sample_clk_enable,
    output logic                  corr_reset,
    output logic                  cfg_pending,
    output logic                  cmd_error
);

    localparam int IW = $clog2(REG_WIDTH) + 1;
    localparam int NW = $clog2(REG_WIDTH) - 2;
    localparam logic [IW-1:0] FULL = IW'(REG_WIDTH);
    localparam logic [IW-1:0] STEP = IW'(4);

    state_t                state, state_n;
    tgt_t                  last_tgt, last_n, tgt;
    logic [IW-1:0]         ridx, ridx_n;
    logic [NW-1:0]         nidx;
    logic [2:0]            en_sh, en_n, en_act;
    logic [3:0]            op, pl;
    logic                  wr, err, apply, apply_d;
    logic                  rs_integ, rs_sample, rs_line;
    logic [REG_WIDTH-1:0]  sh_integ, sh_sample, sh_line;

    assign op  = rx_data[3:0];
    assign pl  = rx_data[7:4];
    assign tgt = op_target(op);

    always_comb begin
        state_n   = state;
        ridx_n    = ridx;
        last_n    = last_tgt;
        nidx      = ridx[IW-2:2];
        en_n      = en_sh;
        wr        = 1'b0;
        err       = 1'b0;
        apply     = 1'b0;
        rs_integ  = 1'b0;
        rs_sample = 1'b0;
        rs_line   = 1'b0;
        if (state == ST_PENDING) begin
            // A full restore is the only way to back out of a waiting commit
            if (rx_valid && op == OP_RESTORE && pl == RS_ALL) begin
                rs_integ  = 1'b1;
                rs_sample = 1'b1;
                rs_line   = 1'b1;
                en_n      = INIT_ENABLES;
                ridx_n    = '0;
                state_n   = ST_IDLE;
            end else begin
                err = rx_valid;
                if (integ_boundary) begin
                    apply   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
        end else if (rx_valid) begin
            case (op)
                OP_RESTORE: begin
                    ridx_n    = '0;
                    rs_integ  = pl == RS_INTEG  || pl == RS_ALL;
                    rs_sample = pl == RS_SAMPLE || pl == RS_ALL;
                    rs_line   = pl == RS_LINE   || pl == RS_ALL;
                    en_n      = (pl == RS_ENABLES || pl == RS_ALL) ? INIT_ENABLES : en_sh;
                    err       = !(pl inside {RS_INTEG, RS_SAMPLE, RS_LINE, RS_ENABLES, RS_ALL});
                end
                OP_LOAD_INTEG, OP_LOAD_SAMPLE, OP_LOAD_LINE: begin
                    last_n = tgt;
                    if (tgt != last_tgt) begin
                        nidx   = '0;
                        wr     = 1'b1;
                        ridx_n = STEP;
                    end else if (ridx == FULL) begin
                        err = 1'b1;
                    end else begin
                        wr     = 1'b1;
                        ridx_n = ridx + STEP;
                    end
                end
                OP_ENABLES: en_n = pl[2:0];
                OP_COMMIT: begin
                    ridx_n = '0;
                    if (en_sh[1] || en_act[1])
                        state_n = ST_PENDING;
                    else
                        apply = 1'b1;
                end
                default: err = 1'b1;
            endcase
        end
    end

    corr_shadow_reg #(.WIDTH(REG_WIDTH), .INIT(INIT_INTEG_TIME)) u_sh_integ (
        .clk(clk), .rst(rst), .wr(wr && tgt == TGT_INTEG), .restore(rs_integ),
        .nidx(nidx), .nib(pl), .q(sh_integ)
    );

    corr_shadow_reg #(.WIDTH(REG_WIDTH), .INIT(INIT_SAMPLE_TIME)) u_sh_sample (
        .clk(clk), .rst(rst), .wr(wr && tgt == TGT_SAMPLE), .restore(rs_sample),
        .nidx(nidx), .nib(pl), .q(sh_sample)
    );

    corr_shadow_reg #(.WIDTH(REG_WIDTH), .INIT(INIT_ACTIVE_LINE)) u_sh_line (
        .clk(clk), .rst(rst), .wr(wr && tgt == TGT_LINE), .restore(rs_line),
        .nidx(nidx), .nib(pl), .q(sh_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            ridx             <= '0;
            last_tgt         <= TGT_NONE;
            en_sh            <= INIT_ENABLES;
            en_act           <= INIT_ENABLES;
            active_line      <= INIT_ACTIVE_LINE;
            sample_time      <= INIT_SAMPLE_TIME;
            integration_time <= INIT_INTEG_TIME;
            apply_d          <= 1'b0;
            corr_reset       <= 1'b0;
            cmd_error        <= 1'b0;
        end else begin
            state      <= state_n;
            ridx       <= ridx_n;
            last_tgt   <= last_n;
            en_sh      <= en_n;
            apply_d    <= apply;
            corr_reset <= apply_d;
            cmd_error  <= err;
            if (apply) begin
                active_line      <= sh_line;
                sample_time      <= sh_sample;
                integration_time <= sh_integ;
                en_act           <= en_sh;
            end
        end
    end

    assign transmit_enable   = en_act[2];
    assign integ_clk_enable  = en_act[1];
    assign sample_clk_enable = en_act[0];
    assign cfg_pending       = state == ST_PENDING;

endmodule

// File: tb/tb_corr_config_ctrl.sv
// tb_corr_config_ctrl: directed checks of decode, shadow loading, commit timing, cancel and reset
module tb_corr_config_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        integ_boundary = 1'b0;
    logic [63:0] active_line, sample_time, integration_time;
    logic        transmit_enable, integ_clk_enable, sample_clk_enable;
    logic        corr_reset, cfg_pending, cmd_error;
    int          passed = 0;
    int          total = 0;

    corr_config_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .integ_boundary(integ_boundary), .active_line(active_line),
        .sample_time(sample_time), .integration_time(integration_time),
        .transmit_enable(transmit_enable), .integ_clk_enable(integ_clk_enable),
        .sample_clk_enable(sample_clk_enable), .corr_reset(corr_reset),
        .cfg_pending(cfg_pending), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic [7:0] b, input logic v, input logic bnd);
        @(negedge clk);
        rx_data = b;
        rx_valid = v;
        integ_boundary = bnd;
        @(negedge clk);
        rx_valid = 1'b0;
        integ_boundary = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1, 1'b0);
    endtask

    task automatic boundary();
        step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_line", active_line, 64'd0);
        chk("rst_sample", sample_time, 64'd100);
        chk("rst_integ", integration_time, 64'd1000);
        chk("rst_en", {61'd0, transmit_enable, integ_clk_enable, sample_clk_enable}, 64'd0);
        chk("rst_pulses", {61'd0, corr_reset, cfg_pending, cmd_error}, 64'd0);

        send(8'h42); send(8'h52); send(8'h62);
        chk("sample_before_commit", sample_time, 64'd100);
        send(8'h0D);
        chk("sample_applied", sample_time, 64'h654);
        chk("imm_no_pending", cfg_pending, 1'b0);
        chk("imm_crst_lat1", corr_reset, 1'b0);
        tick();
        chk("imm_crst_lat2", corr_reset, 1'b1);
        tick();
        chk("imm_crst_end", corr_reset, 1'b0);

        send(8'h3C);
        send(8'h11);
        send(8'h0D);
        chk("pend_set", cfg_pending, 1'b1);
        chk("pend_integ_held", integration_time, 64'd1000);
        send(8'h0D);
        chk("pend_commit_err", cmd_error, 1'b1);
        tick();
        chk("err_one_cycle", cmd_error, 1'b0);
        chk("pend_en_held", integ_clk_enable, 1'b0);
        boundary();
        chk("bnd_integ", integration_time, 64'h3E1);
        chk("bnd_en", {61'd0, transmit_enable, integ_clk_enable, sample_clk_enable}, 64'd3);
        chk("bnd_pend_clr", cfg_pending, 1'b0);
        tick();
        chk("bnd_crst", corr_reset, 1'b1);

        for (int i = 0; i < 16; i++) send({i[3:0], 4'h3});
        chk("line16_no_err", cmd_error, 1'b0);
        send(8'hF3);
        chk("line17_err", cmd_error, 1'b1);
        send(8'h0D);
        boundary();
        chk("line_full", active_line, 64'hFEDCBA9876543210);

        send(8'h12); send(8'h23); send(8'h0D);
        boundary();
        chk("restart_line", active_line, 64'hFEDCBA9876543212);
        chk("restart_sample", sample_time, 64'h651);

        send(8'h0D);
        chk("cancel_pend", cfg_pending, 1'b1);
        step(8'hF0, 1'b1, 1'b1);
        chk("cancel_pend_clr", cfg_pending, 1'b0);
        chk("cancel_no_apply", active_line, 64'hFEDCBA9876543212);
        chk("cancel_no_err", cmd_error, 1'b0);
        tick();
        chk("cancel_no_crst", corr_reset, 1'b0);
        send(8'h0D);
        boundary();
        chk("restored_line", active_line, 64'd0);
        chk("restored_sample", sample_time, 64'd100);
        chk("restored_integ", integration_time, 64'd1000);
        chk("restored_en", {61'd0, transmit_enable, integ_clk_enable, sample_clk_enable}, 64'd0);

        send(8'h13); send(8'h0D);
        chk("line_imm", active_line, 64'h1);
        send(8'h2C); send(8'h0D);
        send(8'h53);
        chk("pend_load_rej", cmd_error, 1'b1);
        pulse_rst();
        chk("rst_pend_line", active_line, 64'd0);
        chk("rst_pend_flags", {61'd0, corr_reset, cfg_pending, cmd_error}, 64'd0);
        tick();
        chk("rst_no_crst1", corr_reset, 1'b0);
        tick();
        chk("rst_no_crst2", corr_reset, 1'b0);
        boundary();
        chk("rst_no_apply", {61'd0, transmit_enable, integ_clk_enable, sample_clk_enable}, 64'd0);

        send(8'h73);
        pulse_rst();
        send(8'h0D);
        chk("rst_load_line", active_line, 64'd0);
        chk("rst_load_sample", sample_time, 64'd100);
        tick();
        chk("rst_load_crst", corr_reset, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
